imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Owns the single-port instruction memory and shares it between the CPU fetch port and the host loader/debug port.
- After reset it holds the CPU in a BOOT phase while the loader writes the program image. It then switches to RUN, where fetch and loader share the memory under priority arbitration with a fetch starvation guard.
- Sits between the fetch stage in cpu_top and the instruction memory array. The memory has a 1-cycle synchronous read.

Parameters:
ADDR_W, 10, memory index width (depth = 2**ADDR_W = 1024 words)
DATA_W, 16, instruction word width
MAX_WAIT, 4, consecutive denied fetch cycles after which fetch is forced to win (range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch read request; held with f_addr stable until f_gnt
f_addr  in  16  fetch address (PC); only [ADDR_W-1:0] used
f_gnt  out  1  fetch request accepted this cycle (combinational)
f_rvalid  out  1  f_rdata valid (cycle after f_gnt)
f_rdata  out  DATA_W  fetched instruction
l_req  in  1  loader request; held with l_we/l_addr/l_wdata stable until l_gnt
l_we  in  1  1 = write, 0 = read
l_addr  in  16  loader address; only [ADDR_W-1:0] used
l_wdata  in  DATA_W  loader write data
l_gnt  out  1  loader request accepted this cycle (combinational)
l_rvalid  out  1  l_rdata valid (cycle after a granted loader read)
l_rdata  out  DATA_W  loader read data
l_done  in  1  single-cycle pulse: program image complete, leave BOOT
l_boot  in  1  single-cycle pulse: re-enter BOOT (hold CPU)
cpu_stall  out  1  1 while in BOOT
mem_en  out  1  memory access this cycle
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory index
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en && !mem_we

Behaviour:
- Reset (async, rst_n = 0):
  - State = BOOT; cpu_stall = 1.
  - Starvation counter = 0; response owner = NONE.
  - f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en, mem_we = 0. f_rdata, l_rdata, mem_addr, mem_wdata = 0.
- FSM states: BOOT, RUN.
  - BOOT -> RUN on l_done.
  - RUN -> BOOT on l_boot.
  - l_done and l_boot in the same cycle: l_boot wins (stay or enter BOOT).
  - The transition takes effect for arbitration in the next cycle.
- BOOT:
  - f_gnt = 0 always.
  - l_gnt = l_req.
  - Starvation counter held at 0.
- RUN arbitration, one grant per cycle:
  - Fetch wins if f_req && (!l_req || wait_cnt == MAX_WAIT).
  - Otherwise the loader wins if l_req.
  - No grant means mem_en = 0.
- Starvation counter:
  - Increments when f_req && !f_gnt in RUN; saturates at MAX_WAIT.
  - Clears to 0 on f_gnt or !f_req.
- Memory drive (combinational, same cycle as grant):
  - mem_en = f_gnt | l_gnt.
  - mem_we = l_gnt && l_we.
  - mem_addr = low ADDR_W bits of the granted address; upper bits ignored, so addresses wrap modulo depth.
  - mem_wdata = l_wdata when a loader write is granted, else 0.
- Read response pipeline:
  - A registered owner tag (NONE/FETCH/LOAD) is set on each granted read; writes set NONE.
  - Next cycle: f_rvalid = (owner == FETCH), l_rvalid = (owner == LOAD).
  - The matching rdata = mem_rdata; non-matching rdata = 0.
  - Back-to-back reads are sustained at 1 per cycle, from the same or alternating requesters.
- Writes produce no rvalid. A loader write followed the next cycle by a read to the same address returns the new data.
- Entering BOOT with a fetch read already granted: its f_rvalid is still delivered the next cycle (an in-flight response is never dropped). No new fetch grants follow.
- Reset mid-transaction: the outstanding response is discarded and no rvalid is produced after reset release.
- Requesters must not drop req before gnt. Behaviour on withdrawal is defined only as "no grant issued in that cycle".

Test Plan:
- Reset, f_req=1 with f_addr=0x0000, no l_done -> f_gnt=0 and cpu_stall=1 indefinitely. Loader writes 0x1234 to addr 5 -> mem_we=1, mem_addr=5, mem_wdata=0x1234, l_gnt=1 same cycle.
- BOOT load of addrs 0..3, l_done pulse, then fetch 0..3 back-to-back -> cpu_stall falls the cycle after l_done. f_rvalid asserts every cycle with data matching the written words, each one cycle after its f_gnt.
- RUN, l_req and f_req both held continuously, MAX_WAIT=4 -> loader granted 4 cycles, fetch granted on the 5th, pattern repeats; wait_cnt never exceeds 4.
- f_addr=0x0405 (ADDR_W=10) -> mem_addr=0x005; loader read of 0x0005 returns the same word on l_rvalid.
- Fetch read granted in the same cycle l_boot pulses -> f_rvalid delivered next cycle, then cpu_stall=1 and no further f_gnt until l_done. Simultaneous l_done + l_boot -> remains BOOT.
- rst_n asserted the cycle after a loader read grant -> l_rvalid stays 0 after release; all outputs at reset values while rst_n=0.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Fetch, loader, control and memory-side signals of the instruction memory arbiter.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned REQ_ADDR_W = 16;

  // fetch port
  logic                  f_req;
  logic [REQ_ADDR_W-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_W-1:0]     f_rdata;

  // loader / debug port
  logic                  l_req;
  logic                  l_we;
  logic [REQ_ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0]     l_wdata;
  logic                  l_gnt;
  logic                  l_rvalid;
  logic [DATA_W-1:0]     l_rdata;
  logic                  l_done;
  logic                  l_boot;

  // cpu hold
  logic                  cpu_stall;

  // memory array side
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // arbiter side
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_done, l_boot, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, cpu_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // requesters plus memory array side
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_done, l_boot, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, cpu_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between CPU fetch and the host loader.
// BOOT holds the CPU while the loader owns the memory; RUN arbitrates with a
// fetch starvation guard. Grants and memory drive are combinational; read data
// returns one cycle later, steered by a registered owner tag.
module imem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  imem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned REQ_ADDR_W = 16;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_LOAD
  } owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
  logic               f_gnt_c, l_gnt_c;
  logic               unused_addr_bits;

  // State, starvation counter and response owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      owner_q  <= OWN_NONE;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // Next state, arbitration, starvation counting and owner tagging
  always_comb begin
    state_d    = state_q;
    owner_d    = OWN_NONE;
    wait_cnt_d = wait_cnt;
    f_gnt_c    = 1'b0;
    l_gnt_c    = 1'b0;

    // l_boot has priority over l_done
    if (bus.l_boot) begin
      state_d = ST_BOOT;
    end else if (state_q == ST_BOOT && bus.l_done) begin
      state_d = ST_RUN;
    end

    case (state_q)
      ST_BOOT: begin
        l_gnt_c    = bus.l_req;
        wait_cnt_d = '0;
      end
      ST_RUN: begin
        if (bus.f_req && (!bus.l_req || wait_cnt == CNT_W'(MAX_WAIT))) begin
          f_gnt_c = 1'b1;
        end else if (bus.l_req) begin
          l_gnt_c = 1'b1;
        end
        if (f_gnt_c || !bus.f_req) begin
          wait_cnt_d = '0;
        end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // no grant can be visible while reset is held
    if (!rst_n) begin
      f_gnt_c = 1'b0;
      l_gnt_c = 1'b0;
    end

    if (f_gnt_c) begin
      owner_d = OWN_FETCH;
    end else if (l_gnt_c && !bus.l_we) begin
      owner_d = OWN_LOAD;
    end
  end

  // Memory port drive for the granted requester
  always_comb begin
    bus.mem_en    = f_gnt_c | l_gnt_c;
    bus.mem_we    = l_gnt_c & bus.l_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (f_gnt_c) begin
      bus.mem_addr = bus.f_addr[ADDR_W-1:0];
    end else if (l_gnt_c) begin
      bus.mem_addr = bus.l_addr[ADDR_W-1:0];
      if (bus.l_we) begin
        bus.mem_wdata = bus.l_wdata;
      end
    end
  end

  // Read response steering from the owner tag
  always_comb begin
    bus.f_rvalid = (owner_q == OWN_FETCH);
    bus.l_rvalid = (owner_q == OWN_LOAD);
    bus.f_rdata  = bus.f_rvalid ? bus.mem_rdata : '0;
    bus.l_rdata  = bus.l_rvalid ? bus.mem_rdata : '0;
  end

  assign bus.f_gnt     = f_gnt_c;
  assign bus.l_gnt     = l_gnt_c;
  assign bus.cpu_stall = (state_q == ST_BOOT);

  // address bits above the memory index wrap and are deliberately ignored
  assign unused_addr_bits = ^{bus.f_addr[REQ_ADDR_W-1:ADDR_W], bus.l_addr[REQ_ADDR_W-1:ADDR_W]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: bench-side memory array, reference image and
// read-response scoreboard queues with due-cycle tags.
module tb_imem_arbiter;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned MAX_WAIT = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  exp_t f_q[$];
  exp_t l_q[$];

  logic [DATA_W-1:0] ref_mem [1024];
  logic [DATA_W-1:0] mem     [1024];
  logic [DATA_W-1:0] rdata_q;

  imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // single-port memory with 1-cycle synchronous read
  always @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // response monitor: each queued read must return exactly on its due cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (f_q.size() > 0 && f_q[0].due == cyc) begin
        chk("f_rvalid", 32'(bus.f_rvalid), 32'd1);
        chk("f_rdata", 32'(bus.f_rdata), 32'(f_q[0].data));
        void'(f_q.pop_front());
      end else begin
        chk("f_rvalid_idle", 32'(bus.f_rvalid), 32'd0);
        chk("f_rdata_idle", 32'(bus.f_rdata), 32'd0);
      end
      if (l_q.size() > 0 && l_q[0].due == cyc) begin
        chk("l_rvalid", 32'(bus.l_rvalid), 32'd1);
        chk("l_rdata", 32'(bus.l_rdata), 32'(l_q[0].data));
        void'(l_q.pop_front());
      end else begin
        chk("l_rvalid_idle", 32'(bus.l_rvalid), 32'd0);
        chk("l_rdata_idle", 32'(bus.l_rdata), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
    bus.l_done  = 1'b0;
    bus.l_boot  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cpu_stall"}, 32'(bus.cpu_stall), 32'd1);
    chk({tag, "_f_gnt"},     32'(bus.f_gnt),     32'd0);
    chk({tag, "_l_gnt"},     32'(bus.l_gnt),     32'd0);
    chk({tag, "_f_rvalid"},  32'(bus.f_rvalid),  32'd0);
    chk({tag, "_l_rvalid"},  32'(bus.l_rvalid),  32'd0);
    chk({tag, "_f_rdata"},   32'(bus.f_rdata),   32'd0);
    chk({tag, "_l_rdata"},   32'(bus.l_rdata),   32'd0);
    chk({tag, "_mem_en"},    32'(bus.mem_en),    32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  // one granted loader write, expected to win immediately
  task automatic lwrite(input logic [15:0] a, input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] idx;
    idx         = a[ADDR_W-1:0];
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = a;
    bus.l_wdata = d;
    @(negedge clk);
    chk("lw_l_gnt", 32'(bus.l_gnt), 32'd1);
    chk("lw_mem_we", 32'(bus.mem_we), 32'd1);
    chk("lw_mem_addr", 32'(bus.mem_addr), 32'(idx));
    chk("lw_mem_wdata", 32'(bus.mem_wdata), 32'(d));
    ref_mem[idx] = d;
    step();
    bus.l_req = 1'b0;
    bus.l_we  = 1'b0;
  endtask

  initial begin
    logic exp_f;
    logic [ADDR_W-1:0] ia;
    rst_n = 1'b0;
    idle_inputs();

    // reset values
    repeat (2) @(negedge clk);
    check_reset("rst");
    step();
    rst_n = 1'b1;

    // BOOT: fetch held off indefinitely
    bus.f_req  = 1'b1;
    bus.f_addr = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("boot_f_gnt", 32'(bus.f_gnt), 32'd0);
      chk("boot_stall", 32'(bus.cpu_stall), 32'd1);
      step();
    end

    // BOOT: loader write of 0x1234 to addr 5 with fetch still pending
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_addr  = 16'h0005;
    bus.l_wdata = 16'h1234;
    @(negedge clk);
    chk("boot_lw_l_gnt", 32'(bus.l_gnt), 32'd1);
    chk("boot_lw_f_gnt", 32'(bus.f_gnt), 32'd0);
    chk("boot_lw_mem_en", 32'(bus.mem_en), 32'd1);
    chk("boot_lw_mem_we", 32'(bus.mem_we), 32'd1);
    chk("boot_lw_mem_addr", 32'(bus.mem_addr), 32'h005);
    chk("boot_lw_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    ref_mem[5] = 16'h1234;
    step();
    idle_inputs();

    // image load 0..3
    for (int i = 0; i < 4; i++) lwrite(16'(i), 16'hA000 + 16'(i * 16'h0111));

    // leave BOOT: stall drops the cycle after l_done
    bus.l_done = 1'b1;
    @(negedge clk);
    chk("done_stall_same", 32'(bus.cpu_stall), 32'd1);
    step();
    bus.l_done = 1'b0;
    @(negedge clk);
    chk("done_stall_next", 32'(bus.cpu_stall), 32'd0);
    step();

    // back-to-back fetch 0..3
    for (int i = 0; i < 4; i++) begin
      bus.f_req  = 1'b1;
      bus.f_addr = 16'(i);
      ia         = ADDR_W'(i);
      @(negedge clk);
      chk("fetch_f_gnt", 32'(bus.f_gnt), 32'd1);
      chk("fetch_mem_addr", 32'(bus.mem_addr), 32'(ia));
      chk("fetch_mem_we", 32'(bus.mem_we), 32'd0);
      f_q.push_back('{data: ref_mem[ia], due: cyc + 1});
      step();
    end
    bus.f_req = 1'b0;
    @(negedge clk);
    step();

    // contention: loader 4 cycles, then starved fetch forced through
    bus.f_req  = 1'b1;
    bus.f_addr = 16'h0001;
    bus.l_req  = 1'b1;
    bus.l_we   = 1'b0;
    bus.l_addr = 16'h0002;
    for (int k = 0; k < 15; k++) begin
      exp_f = ((k % 5) == 4);
      @(negedge clk);
      chk("arb_wait_cnt", 32'(dut.wait_cnt), 32'(k % 5));
      chk("arb_f_gnt", 32'(bus.f_gnt), 32'(exp_f));
      chk("arb_l_gnt", 32'(bus.l_gnt), 32'(!exp_f));
      if (exp_f) f_q.push_back('{data: ref_mem[1], due: cyc + 1});
      else       l_q.push_back('{data: ref_mem[2], due: cyc + 1});
      step();
    end
    idle_inputs();

    // address wrap: 0x0405 and 0x0005 hit the same word
    bus.f_req  = 1'b1;
    bus.f_addr = 16'h0405;
    @(negedge clk);
    chk("wrap_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("wrap_mem_addr", 32'(bus.mem_addr), 32'h005);
    f_q.push_back('{data: ref_mem[5], due: cyc + 1});
    step();
    bus.f_req  = 1'b0;
    bus.l_req  = 1'b1;
    bus.l_we   = 1'b0;
    bus.l_addr = 16'h0005;
    @(negedge clk);
    chk("wrap_l_gnt", 32'(bus.l_gnt), 32'd1);
    chk("wrap_l_mem_addr", 32'(bus.mem_addr), 32'h005);
    l_q.push_back('{data: ref_mem[5], due: cyc + 1});
    step();
    bus.l_req = 1'b0;

    // write through a wrapped address, read it back the very next cycle
    lwrite(16'h07FF, 16'hBEEF);
    bus.l_req  = 1'b1;
    bus.l_we   = 1'b0;
    bus.l_addr = 16'h03FF;
    @(negedge clk);
    chk("wr_rd_l_gnt", 32'(bus.l_gnt), 32'd1);
    l_q.push_back('{data: ref_mem[10'h3FF], due: cyc + 1});
    step();
    bus.l_req = 1'b0;

    // fetch granted in the l_boot cycle still returns its data
    bus.f_req  = 1'b1;
    bus.f_addr = 16'h0002;
    bus.l_boot = 1'b1;
    @(negedge clk);
    chk("lboot_f_gnt", 32'(bus.f_gnt), 32'd1);
    chk("lboot_stall_same", 32'(bus.cpu_stall), 32'd0);
    f_q.push_back('{data: ref_mem[2], due: cyc + 1});
    step();
    bus.l_boot = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reboot_f_gnt", 32'(bus.f_gnt), 32'd0);
      chk("reboot_stall", 32'(bus.cpu_stall), 32'd1);
      step();
    end

    // l_done together with l_boot keeps BOOT
    bus.l_done = 1'b1;
    bus.l_boot = 1'b1;
    @(negedge clk);
    chk("both_f_gnt", 32'(bus.f_gnt), 32'd0);
    step();
    bus.l_done = 1'b0;
    bus.l_boot = 1'b0;
    @(negedge clk);
    chk("both_stall", 32'(bus.cpu_stall), 32'd1);
    chk("both_f_gnt_after", 32'(bus.f_gnt), 32'd0);
    step();

    // l_done alone releases the pending fetch the following cycle
    bus.l_done = 1'b1;
    @(negedge clk);
    chk("rel_f_gnt_same", 32'(bus.f_gnt), 32'd0);
    step();
    bus.l_done = 1'b0;
    @(negedge clk);
    chk("rel_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rel_f_gnt", 32'(bus.f_gnt), 32'd1);
    f_q.push_back('{data: ref_mem[2], due: cyc + 1});
    step();
    bus.f_req = 1'b0;
    @(negedge clk);
    step();

    // reset right after a granted loader read discards its response
    bus.l_req  = 1'b1;
    bus.l_we   = 1'b0;
    bus.l_addr = 16'h0003;
    @(negedge clk);
    chk("mid_l_gnt", 32'(bus.l_gnt), 32'd1);
    step();
    rst_n     = 1'b0;
    bus.f_req = 1'b1;
    f_q.delete();
    l_q.delete();
    @(negedge clk);
    check_reset("midrst");
    step();
    idle_inputs();
    @(negedge clk);
    check_reset("midrst_idle");
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
      chk("post_rst_stall", 32'(bus.cpu_stall), 32'd1);
      step();
    end

    chk("f_q_drained", 32'(f_q.size()), 32'd0);
    chk("l_q_drained", 32'(l_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
